// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer: turns EX branch/jump resolution into pc_sel, redirect target and flush bubbles.
// A redirect seen under a memory stall is parked in HOLD, and load-use bubbles are merged in RUN.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ld_use,
  output logic             pc_sel,
  output logic [31:0]      redirect_pc,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             if_id_hold,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0]       CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             sent_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] taken_count_q;

  logic evt;
  logic in_run;
  logic in_flush;

  assign evt      = ex_valid & (ex_is_jump | (ex_is_branch & ex_taken));
  assign in_run   = (state_q == S_RUN);
  assign in_flush = (state_q == S_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      cnt_q         <= 3'd0;
      sent_q        <= 1'b0;
      redirect_pc_q <= 32'd0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          // Entry into HOLD is counted as an accepted redirect even though stalled.
          if (evt) begin
            redirect_pc_q <= ex_target;
            taken_count_q <= taken_count_q + CNT_ONE;
            if (stall_in) begin
              state_q <= S_HOLD;
            end else begin
              cnt_q   <= CNT_INIT;
              sent_q  <= 1'b0;
              state_q <= S_FLUSH;
            end
          end
          if (!stall_in && ex_valid && ex_is_branch) begin
            br_count_q <= br_count_q + CNT_ONE;
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            cnt_q   <= CNT_INIT;
            sent_q  <= 1'b0;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Wrong-path events are ignored here; only unstalled cycles advance the flush.
          if (!stall_in) begin
            sent_q <= 1'b1;
            if (cnt_q == 3'd0) begin
              state_q <= S_RUN;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign pc_sel      = in_flush & ~sent_q & ~stall_in;
  assign redirect_pc = redirect_pc_q;
  assign if_id_flush = in_flush;
  assign id_ex_flush = in_flush | (in_run & ld_use);
  assign if_id_hold  = in_run & ld_use;
  assign busy        = ~in_run;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboarded bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_branch_redirect_ctrl;

  localparam int FC = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_in, ex_valid, ex_is_branch, ex_is_jump, ex_taken, ld_use;
  logic [31:0]   ex_target;
  logic          pc_sel, if_id_flush, id_ex_flush, if_id_hold, busy;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] br_count, taken_count;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
    .ex_target(ex_target), .ld_use(ld_use), .pc_sel(pc_sel),
    .redirect_pc(redirect_pc), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .if_id_hold(if_id_hold), .busy(busy),
    .br_count(br_count), .taken_count(taken_count)
  );

  typedef struct {
    logic          pc_sel, ifl, idl, hold, busy;
    logic [31:0]   rpc;
    logic [CW-1:0] br, tk;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: pending flag, remaining flush cycles, whether the PC load was issued.
  bit          m_pend;
  int          m_left;
  bit          m_iss;
  logic [31:0] m_pc;
  int          m_br, m_tk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_left = 0; m_iss = 0; m_pc = 32'd0; m_br = 0; m_tk = 0;
  endtask

  task automatic drive(input bit st, input bit v, input bit b, input bit j,
                       input bit t, input logic [31:0] tg, input bit ld);
    exp_t e;
    bit   flushing, idle, ev;
    @(posedge clk);
    #1;
    stall_in = st; ex_valid = v; ex_is_branch = b; ex_is_jump = j;
    ex_taken = t; ex_target = tg; ld_use = ld;
    flushing  = (m_left > 0);
    idle      = !flushing && !m_pend;
    ev        = v && (j || (b && t));
    e.pc_sel  = flushing && !m_iss && !st;
    e.ifl     = flushing;
    e.idl     = flushing || (idle && ld);
    e.hold    = idle && ld;
    e.busy    = !idle;
    e.rpc     = m_pc;
    e.br      = CW'(m_br);
    e.tk      = CW'(m_tk);
    sbq.push_back(e);
    if (flushing) begin
      if (!st) begin
        m_iss  = 1;
        m_left = m_left - 1;
      end
    end else if (m_pend) begin
      if (!st) begin
        m_pend = 0; m_left = FC; m_iss = 0;
      end
    end else begin
      if (ev) begin
        m_pc = tg;
        m_tk = (m_tk + 1) % (1 << CW);
        if (st) m_pend = 1;
        else begin
          m_left = FC; m_iss = 0;
        end
      end
      if (!st && v && b) m_br = (m_br + 1) % (1 << CW);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'd0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pc_sel"}, 32'(pc_sel), 32'd0);
    chk({tag, "_if_id_flush"}, 32'(if_id_flush), 32'd0);
    chk({tag, "_id_ex_flush"}, 32'(id_ex_flush), 32'd0);
    chk({tag, "_if_id_hold"}, 32'(if_id_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_br_count"}, 32'(br_count), 32'd0);
    chk({tag, "_taken_count"}, 32'(taken_count), 32'd0);
  endtask

  // Pulse reset between edges, sampling outputs while it is asserted.
  task automatic async_reset_pulse(input string tag);
    @(negedge clk);
    #2;
    stall_in = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0;
    ex_taken = 0; ld_use = 0;
    rst = 1;
    #1;
    check_zero_outputs(tag);
    rst = 0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
        chk("if_id_flush", 32'(if_id_flush), 32'(e.ifl));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e.idl));
        chk("if_id_hold", 32'(if_id_hold), 32'(e.hold));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("br_count", 32'(br_count), 32'(e.br));
        chk("taken_count", 32'(taken_count), 32'(e.tk));
      end
    end
  end

  initial begin : stim
    logic [31:0] tg;
    rst = 1;
    stall_in = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0;
    ex_taken = 0; ex_target = 32'd0; ld_use = 0;
    #2;
    check_zero_outputs("reset");
    #10;
    rst = 0;
    model_reset();

    // Taken BEQ to 0x40, then not-taken BNE.
    idle_cycles(3);
    drive(0, 1, 1, 0, 1, 32'h40, 0);
    idle_cycles(4);
    drive(0, 1, 1, 0, 0, 32'h80, 0);
    idle_cycles(2);

    // JAL under a 3-cycle stall.
    drive(1, 1, 0, 1, 0, 32'h100, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 0);
    idle_cycles(5);

    // Stall in the middle of a flush.
    drive(0, 1, 1, 0, 1, 32'h40, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 0);
    idle_cycles(4);

    // Wrong-path redirect plus load-use during flush, then load-use in RUN.
    drive(0, 1, 1, 0, 1, 32'h40, 0);
    drive(0, 1, 0, 1, 1, 32'h200, 1);
    idle_cycles(2);
    drive(0, 0, 0, 0, 0, 32'd0, 1);
    drive(0, 1, 0, 1, 0, 32'h0, 1);
    idle_cycles(3);

    // Reset in the middle of FLUSH, then of HOLD.
    drive(0, 1, 1, 0, 1, 32'h44, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 0);
    async_reset_pulse("rst_flush");
    idle_cycles(2);
    drive(1, 1, 0, 1, 0, 32'h88, 0);
    async_reset_pulse("rst_hold");
    idle_cycles(2);

    // 17 taken branches wrap a 4-bit counter to 1.
    async_reset_pulse("rst_wrap");
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 1, 0, 1, 32'(i * 4), 0);
      idle_cycles(2);
    end
    @(negedge clk);
    #1;
    chk("wrap_taken_count", 32'(taken_count), 32'd1);
    chk("wrap_br_count", 32'(br_count), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      tg = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), tg, ($urandom_range(0, 4) == 0));
    end
    idle_cycles(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
